// File: rtl/aes_serial_pkg.sv
// Shared types and sizes for the serial AES front end (sequencer and SIPO/PISO datapath).
package aes_serial_pkg;

  localparam int NB_DEF   = 4;
  localparam int NK_DEF   = 8;
  localparam int BLK_BITS = 32 * NB_DEF;
  localparam int KEY_BITS = 32 * NK_DEF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_MSG  = 3'd1,
    LOAD_KEY  = 3'd2,
    START     = 3'd3,
    WAIT_CORE = 3'd4,
    UNLOAD    = 3'd5,
    SHIFT_OUT = 3'd6,
    FIN       = 3'd7
  } seq_state_e;

  // Bits needed to hold 0..max_val; never less than one.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/aes_bit_counter.sv
// Clearable, saturating up-counter with a terminal-count compare.
module aes_bit_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt;

  // Clear wins over increment; the count saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/aes_serial_seq_ctrl.sv
// Sequencer for the serial AES front end: message load, key load, one core run, result unload.
module aes_serial_seq_ctrl
  import aes_serial_pkg::*;
#(
  parameter int nb      = NB_DEF,
  parameter int nk      = NK_DEF,
  parameter int nr      = 14,
  parameter int TIMEOUT = 64
) (
  input  logic in_clk,
  input  logic rst,
  input  logic en,
  input  logic start,
  input  logic mode,
  input  logic in_valid,
  input  logic core_done,
  input  logic out_ready,
  output logic msg_shift,
  output logic key_shift,
  output logic core_start,
  output logic core_mode,
  output logic piso_load,
  output logic piso_shift,
  output logic out_valid,
  output logic busy,
  output logic done,
  output logic err_timeout
);

  // nr only matters to the core; folded in here so the parameter set stays uniform with it.
  localparam int BLK    = 32 * nb + 0 * nr;
  localparam int KEY    = 32 * nk;
  localparam int BW     = cnt_width(32 * ((nb > nk) ? nb : nk));
  localparam int TW     = cnt_width(TIMEOUT);
  localparam bit TMO_EN = (TIMEOUT != 0);

  localparam logic [BW-1:0] BLK_LAST = BW'(BLK - 1);
  localparam logic [BW-1:0] KEY_LAST = BW'(KEY - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  seq_state_e state, state_next;
  logic bit_clr, bit_inc, bit_tc, tmo_clr, tmo_inc, tmo_tc;
  logic mode_load, err_set, err_clr;
  logic [BW-1:0] bit_tc_val;

  assign bit_tc_val = (state == LOAD_KEY) ? KEY_LAST : BLK_LAST;

  aes_bit_counter #(.W(BW)) u_bit_cnt (
    .clk(in_clk), .rst(rst), .clr(bit_clr), .inc(bit_inc), .tc_val(bit_tc_val), .tc(bit_tc)
  );

  aes_bit_counter #(.W(TW)) u_tmo_cnt (
    .clk(in_clk), .rst(rst), .clr(tmo_clr), .inc(tmo_inc), .tc_val(TMO_LAST), .tc(tmo_tc)
  );

  // State register.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (en) begin
      state <= state_next;
    end else begin
      state <= state;
    end
  end

  // Next state, counter controls and the Mealy shift strobes; everything idles while en=0.
  always_comb begin
    state_next = state;
    bit_clr    = 1'b0;
    bit_inc    = 1'b0;
    tmo_clr    = 1'b0;
    tmo_inc    = 1'b0;
    mode_load  = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    msg_shift  = 1'b0;
    key_shift  = 1'b0;
    piso_shift = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next = LOAD_MSG;
            mode_load  = 1'b1;
            err_clr    = 1'b1;
            bit_clr    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
        LOAD_MSG, LOAD_KEY: begin
          msg_shift = (state == LOAD_MSG) && in_valid;
          key_shift = (state == LOAD_KEY) && in_valid;
          if (in_valid && bit_tc) begin
            state_next = (state == LOAD_MSG) ? LOAD_KEY : START;
            bit_clr    = 1'b1;
          end else begin
            bit_inc = in_valid;
          end
        end
        START: begin
          state_next = WAIT_CORE;
          tmo_clr    = 1'b1;
        end
        WAIT_CORE: begin
          // A done arriving on the threshold cycle still wins over the timeout.
          if (core_done) begin
            state_next = UNLOAD;
          end else if (TMO_EN && tmo_tc) begin
            state_next = IDLE;
            err_set    = 1'b1;
          end else begin
            tmo_inc = 1'b1;
          end
        end
        UNLOAD: begin
          state_next = SHIFT_OUT;
          bit_clr    = 1'b1;
        end
        SHIFT_OUT: begin
          piso_shift = out_ready;
          if (out_ready && bit_tc) begin
            state_next = FIN;
          end else begin
            bit_inc = out_ready;
          end
        end
        FIN: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end else begin
      state_next = state;
    end
  end

  assign out_valid = piso_shift;

  // Registered status and strobes, decoded from the state being entered.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      core_start  <= 1'b0;
      piso_load   <= 1'b0;
      done        <= 1'b0;
      core_mode   <= 1'b0;
      err_timeout <= 1'b0;
    end else if (en) begin
      busy        <= (state_next != IDLE);
      core_start  <= (state_next == START);
      piso_load   <= (state_next == UNLOAD);
      done        <= (state_next == FIN);
      core_mode   <= mode_load ? mode : core_mode;
      err_timeout <= err_set ? 1'b1 : (err_clr ? 1'b0 : err_timeout);
    end else begin
      busy        <= busy;
      core_start  <= core_start;
      piso_load   <= piso_load;
      done        <= done;
      core_mode   <= core_mode;
      err_timeout <= err_timeout;
    end
  end

endmodule

// File: tb/tb_aes_serial_seq_ctrl.sv
// Scoreboarded bench for the serial AES sequencer: per-run expectations queued at stimulus time, checked at run end.
module tb_aes_serial_seq_ctrl;
  import aes_serial_pkg::*;

  logic in_clk = 1'b0;
  logic rst, en, start, mode, in_valid, core_done, out_ready;
  logic msg_shift, key_shift, core_start, core_mode, piso_load, piso_shift;
  logic out_valid, busy, done, err_timeout;

  aes_serial_seq_ctrl dut (
    .in_clk(in_clk), .rst(rst), .en(en), .start(start), .mode(mode), .in_valid(in_valid),
    .core_done(core_done), .out_ready(out_ready), .msg_shift(msg_shift), .key_shift(key_shift),
    .core_start(core_start), .core_mode(core_mode), .piso_load(piso_load), .piso_shift(piso_shift),
    .out_valid(out_valid), .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  always #5 in_clk = ~in_clk;

  int cyc = 0;
  always @(posedge in_clk) cyc <= cyc + 1;

  typedef struct {
    int msg; int key; int outs; int cs_gap; int cs_after_key; int out_lat; int done_lat; int dones; bit err;
  } exp_t;
  exp_t sb[$];

  int compared = 0, mismatched = 0;
  int cd_cyc = 0;

  // Monitor: per-run counts and event cycles, restarted whenever busy rises.
  int m_msg = 0, m_key = 0, m_out = 0, m_first = 0, m_cs = 0, m_cs_n = 0, m_last_key = 0;
  int m_first_out = -1, m_last_out = 0, m_done_cyc = 0, m_dones = 0, m_err_cyc = 0;
  int m_ends = 0, m_runs = 0, m_loads = 0, m_ov_bad = 0, m_bp_bad = 0;
  bit m_err_start = 1'b0;
  logic busy_q = 1'b0, err_q = 1'b0;

  always @(negedge in_clk) begin
    busy_q <= busy;
    err_q  <= err_timeout;
    if (out_valid !== piso_shift) m_ov_bad <= m_ov_bad + 1;
    if (piso_shift && !out_ready) m_bp_bad <= m_bp_bad + 1;
    if (piso_load) m_loads <= m_loads + 1;
    if (busy && !busy_q) begin
      m_runs      <= m_runs + 1;
      m_first     <= cyc;
      m_msg       <= msg_shift ? 1 : 0;
      m_key       <= 0;
      m_out       <= 0;
      m_cs_n      <= 0;
      m_dones     <= 0;
      m_first_out <= -1;
      m_err_start <= err_timeout;
    end else begin
      if (msg_shift) m_msg <= m_msg + 1;
      if (key_shift) begin m_key <= m_key + 1; m_last_key <= cyc; end
      if (core_start) begin m_cs_n <= m_cs_n + 1; m_cs <= cyc; end
      if (piso_shift) begin
        m_out <= m_out + 1;
        m_last_out <= cyc;
        if (m_first_out < 0) m_first_out <= cyc;
      end
      if (done) begin m_dones <= m_dones + 1; m_done_cyc <= cyc; end
    end
    if (done || (err_timeout && !err_q)) begin
      m_ends <= m_ends + 1;
      if (!done) m_err_cyc <= cyc;
    end
  end

  // Stimulus for one run; returns one cycle after the run's done/err event (or on budget expiry).
  task automatic drive_run(input bit md, input int vpat, input int rpat, input int cd_delay, input bit hold_start);
    int ends0;
    bit fin;
    ends0 = m_ends;
    fin = 1'b0;
    @(posedge in_clk); #1;
    start = 1'b1; mode = md; in_valid = 1'b1; out_ready = 1'b1; core_done = 1'b0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      @(posedge in_clk); #1;
      start     = hold_start && (k < 300);
      in_valid  = (vpat == 0) ? 1'b1 : cyc[0];
      out_ready = (rpat == 0) ? 1'b1 : ((cyc % 3) != 0);
      core_done = (cd_delay >= 0) && (k > 2) && (m_cs_n > 0) && (cyc == m_cs + cd_delay);
      if (core_done) cd_cyc = cyc;
      if (m_ends != ends0) fin = 1'b1;
    end
    compared++;
    if (!fin) begin
      mismatched++;
      $display("FAIL run_end: run never reached done/err_timeout within 3000 cycles (got none, want one)");
    end
    start = 1'b0; in_valid = 1'b0; core_done = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge in_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0; core_done = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge in_clk);
    compared++;
    if ({msg_shift, key_shift, core_start, core_mode, piso_load, piso_shift, out_valid, busy, done, err_timeout} !== 10'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b want 0000000000",
        {msg_shift, key_shift, core_start, core_mode, piso_load, piso_shift, out_valid, busy, done, err_timeout});
    end
    @(posedge in_clk); #1; rst = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge in_clk);
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    exp_t e;
    sb.push_back('{msg:BLK_BITS, key:KEY_BITS, outs:BLK_BITS, cs_gap:BLK_BITS+KEY_BITS, cs_after_key:1,
                   out_lat:2, done_lat:1, dones:1, err:1'b0});
    drive_run(1'b1, 0, 0, 10, 1'b0);
    e = sb.pop_front();
    compared++; if (m_cs - m_first !== e.cs_gap) begin mismatched++; $display("FAIL basic_cs_latency: got %0d want %0d", m_cs - m_first, e.cs_gap); end
    compared++; if (m_out !== e.outs) begin mismatched++; $display("FAIL basic_out_count: got %0d want %0d", m_out, e.outs); end
    compared++; if (m_first_out - cd_cyc !== e.out_lat) begin mismatched++; $display("FAIL basic_done_to_out: got %0d want %0d", m_first_out - cd_cyc, e.out_lat); end
    compared++; if (m_done_cyc - m_last_out !== e.done_lat) begin mismatched++; $display("FAIL basic_out_to_done: got %0d want %0d", m_done_cyc - m_last_out, e.done_lat); end
    compared++; if (m_dones !== e.dones) begin mismatched++; $display("FAIL basic_done_pulses: got %0d want %0d", m_dones, e.dones); end
    compared++; if (m_cs_n !== 1) begin mismatched++; $display("FAIL basic_core_start_width: got %0d want 1", m_cs_n); end
    compared++; if (core_mode !== 1'b1) begin mismatched++; $display("FAIL basic_core_mode: got %b want 1", core_mode); end
  endtask

  task automatic test_toggle_valid();
    exp_t e;
    sb.push_back('{msg:BLK_BITS, key:KEY_BITS, outs:BLK_BITS, cs_gap:0, cs_after_key:1,
                   out_lat:2, done_lat:1, dones:1, err:1'b0});
    drive_run(1'b0, 1, 0, 10, 1'b0);
    e = sb.pop_front();
    compared++; if (m_msg !== e.msg) begin mismatched++; $display("FAIL toggle_msg_shift: got %0d want %0d", m_msg, e.msg); end
    compared++; if (m_key !== e.key) begin mismatched++; $display("FAIL toggle_key_shift: got %0d want %0d", m_key, e.key); end
    compared++; if (m_cs - m_last_key !== e.cs_after_key) begin mismatched++; $display("FAIL toggle_cs_after_key: got %0d want %0d", m_cs - m_last_key, e.cs_after_key); end
  endtask

  task automatic test_timeout();
    exp_t e;
    // WAIT_CORE spans 64 cycles after the core_start cycle; the sticky flag shows one cycle later.
    sb.push_back('{msg:BLK_BITS, key:KEY_BITS, outs:0, cs_gap:65, cs_after_key:1,
                   out_lat:0, done_lat:0, dones:0, err:1'b1});
    drive_run(1'b0, 0, 0, -1, 1'b0);
    e = sb.pop_front();
    compared++; if (err_timeout !== e.err) begin mismatched++; $display("FAIL timeout_flag: got %b want %b", err_timeout, e.err); end
    compared++; if (m_err_cyc - m_cs !== e.cs_gap) begin mismatched++; $display("FAIL timeout_latency: got %0d want %0d", m_err_cyc - m_cs, e.cs_gap); end
    compared++; if (m_dones !== e.dones || m_out !== e.outs) begin mismatched++; $display("FAIL timeout_no_done: got done=%0d outs=%0d want 0/0", m_dones, m_out); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL timeout_busy: got %b want 0", busy); end
    compared++; if (core_mode !== 1'b0) begin mismatched++; $display("FAIL timeout_core_mode: got %b want 0", core_mode); end
    sb.push_back('{msg:BLK_BITS, key:KEY_BITS, outs:BLK_BITS, cs_gap:0, cs_after_key:1,
                   out_lat:2, done_lat:1, dones:1, err:1'b0});
    drive_run(1'b1, 0, 0, 10, 1'b0);
    e = sb.pop_front();
    compared++; if (m_err_start !== e.err) begin mismatched++; $display("FAIL timeout_cleared_by_start: got %b want %b", m_err_start, e.err); end
    compared++; if (m_dones !== e.dones) begin mismatched++; $display("FAIL timeout_next_run_done: got %0d want %0d", m_dones, e.dones); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int ov0, bp0;
    ov0 = m_ov_bad; bp0 = m_bp_bad;
    sb.push_back('{msg:BLK_BITS, key:KEY_BITS, outs:BLK_BITS, cs_gap:0, cs_after_key:1,
                   out_lat:0, done_lat:1, dones:1, err:1'b0});
    drive_run(1'b0, 0, 1, 10, 1'b0);
    e = sb.pop_front();
    compared++; if (m_out !== e.outs) begin mismatched++; $display("FAIL bp_out_count: got %0d want %0d", m_out, e.outs); end
    compared++; if (m_bp_bad - bp0 !== 0) begin mismatched++; $display("FAIL bp_shift_without_ready: got %0d want 0", m_bp_bad - bp0); end
    compared++; if (m_ov_bad - ov0 !== 0) begin mismatched++; $display("FAIL bp_out_valid_eq_shift: got %0d want 0", m_ov_bad - ov0); end
    compared++; if (m_done_cyc - m_last_out !== e.done_lat) begin mismatched++; $display("FAIL bp_out_to_done: got %0d want %0d", m_done_cyc - m_last_out, e.done_lat); end
  endtask

  task automatic test_rst_mid();
    exp_t e;
    int k;
    @(posedge in_clk); #1; start = 1'b1; in_valid = 1'b1;
    @(posedge in_clk); #1; start = 1'b0;
    k = 0;
    while (m_msg < 50 && k < 200) begin @(posedge in_clk); #1; k++; end
    rst = 1'b1;
    @(negedge in_clk);
    compared++;
    if ({msg_shift, key_shift, core_start, core_mode, piso_load, piso_shift, out_valid, busy, done, err_timeout} !== 10'd0) begin
      mismatched++;
      $display("FAIL rst_mid_outputs: got %b want 0000000000",
        {msg_shift, key_shift, core_start, core_mode, piso_load, piso_shift, out_valid, busy, done, err_timeout});
    end
    @(posedge in_clk); #1; rst = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge in_clk); #1;
    sb.push_back('{msg:BLK_BITS, key:KEY_BITS, outs:BLK_BITS, cs_gap:BLK_BITS+KEY_BITS, cs_after_key:1,
                   out_lat:2, done_lat:1, dones:1, err:1'b0});
    drive_run(1'b1, 0, 0, 10, 1'b0);
    e = sb.pop_front();
    compared++; if (m_cs - m_first !== e.cs_gap) begin mismatched++; $display("FAIL rst_rerun_cs_latency: got %0d want %0d", m_cs - m_first, e.cs_gap); end
    compared++; if (m_out !== e.outs || m_dones !== e.dones) begin mismatched++; $display("FAIL rst_rerun_out_done: got %0d/%0d want %0d/%0d", m_out, m_dones, e.outs, e.dones); end
  endtask

  task automatic test_start_hold_and_idle_done();
    exp_t e;
    int runs0, loads0;
    runs0 = m_runs; loads0 = m_loads;
    sb.push_back('{msg:BLK_BITS, key:KEY_BITS, outs:BLK_BITS, cs_gap:0, cs_after_key:1,
                   out_lat:2, done_lat:1, dones:1, err:1'b0});
    drive_run(1'b0, 0, 0, 10, 1'b1);
    e = sb.pop_front();
    compared++; if (m_runs - runs0 !== 1) begin mismatched++; $display("FAIL hold_single_run: got %0d runs want 1", m_runs - runs0); end
    compared++; if (m_msg !== e.msg || m_dones !== e.dones) begin mismatched++; $display("FAIL hold_run_counts: got %0d/%0d want %0d/%0d", m_msg, m_dones, e.msg, e.dones); end
    core_done = 1'b1;
    @(posedge in_clk); #1; core_done = 1'b0;
    repeat (4) @(negedge in_clk);
    compared++; if (busy !== 1'b0 || m_runs - runs0 !== 1) begin mismatched++; $display("FAIL idle_core_done_busy: got busy=%b runs=%0d want 0/1", busy, m_runs - runs0); end
    compared++; if (m_loads - loads0 !== 1) begin mismatched++; $display("FAIL idle_core_done_load: got %0d piso_loads want 1", m_loads - loads0); end
  endtask

  task automatic test_done_at_threshold();
    exp_t e;
    sb.push_back('{msg:BLK_BITS, key:KEY_BITS, outs:BLK_BITS, cs_gap:0, cs_after_key:1,
                   out_lat:2, done_lat:1, dones:1, err:1'b0});
    drive_run(1'b0, 0, 0, 64, 1'b0);
    e = sb.pop_front();
    compared++; if (err_timeout !== e.err) begin mismatched++; $display("FAIL edge_no_error: got %b want %b", err_timeout, e.err); end
    compared++; if (m_out !== e.outs || m_dones !== e.dones) begin mismatched++; $display("FAIL edge_unload_path: got %0d/%0d want %0d/%0d", m_out, m_dones, e.outs, e.dones); end
    compared++; if (m_first_out - cd_cyc !== e.out_lat) begin mismatched++; $display("FAIL edge_done_to_out: got %0d want %0d", m_first_out - cd_cyc, e.out_lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle_valid();
    test_timeout();
    test_backpressure();
    test_rst_mid();
    test_start_hold_and_idle_done();
    test_done_at_threshold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
